// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin grant search for stream_mux_n.
// Pure declarations: no latency, no backpressure.
package stream_mux_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    localparam int MAX_N = 16;

    // Returns the first channel with valid set, searching upward from last+1 with wrap; -1 if none.
    function automatic int rr_pick(input logic [MAX_N-1:0] vld, input int last, input int n);
        int idx;
        rr_pick = -1;
        for (int i = 1; i <= MAX_N; i++) begin
            if (i <= n && rr_pick < 0) begin
                idx = (last + i) % n;
                if (vld[idx[3:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// Parametrised N:1 mux of W-bit fields packed at [k*W +: W]; out-of-range select yields 0.
// Combinational, zero latency; no backpressure.
module mux_n_1
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N*W-1:0] i_dat,
    input  logic [SEL_W-1:0] i_sel,
    output logic [W-1:0] o_dat
);

    always_comb begin
        o_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SEL_W'(k)) o_dat = i_dat[k*W +: W];
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input packet stream mux: locks one channel per packet, one output register. Optional STREAM_MUX_RR_EN: round-robin lock instead of sel.
// Latency: 1 cycle from input acceptance to out_*; one idle lock cycle per packet.
// Backpressure: in_ready[grant] = !out_valid || out_ready; out_* held while stalled.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0] in_valid,
    output logic [N-1:0] in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0] in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic [W-1:0] out_data,
    output logic out_last,
    output logic [SEL_W-1:0] out_chan,
    output logic busy,
    output logic sel_err
);

    state_t r_state;
    logic [SEL_W-1:0] r_grant;
    logic r_out_valid;
    logic r_out_last;
    logic [W-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic r_sel_err;

    logic [W-1:0] w_data_grant;
    logic w_last_grant;
    logic w_vld_grant;
    logic w_rdy_grant;
    logic w_accept;
    logic w_lock_go;
    logic [SEL_W-1:0] w_lock_tgt;
    logic w_sel_err;

    mux_n_1 #(.N(N), .W(W)) u_data_mux (.i_dat(in_data),  .i_sel(r_grant), .o_dat(w_data_grant));
    mux_n_1 #(.N(N), .W(1)) u_last_mux (.i_dat(in_last),  .i_sel(r_grant), .o_dat(w_last_grant));
    mux_n_1 #(.N(N), .W(1)) u_vld_mux  (.i_dat(in_valid), .i_sel(r_grant), .o_dat(w_vld_grant));

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] r_last_grant;
    int w_pick;
    logic w_unused_sel;

    assign w_unused_sel = ^sel;

    always_comb begin
        w_pick     = rr_pick(MAX_N'(in_valid), int'(r_last_grant), N);
        w_lock_go  = (w_pick >= 0);
        w_lock_tgt = SEL_W'(w_pick);
        w_sel_err  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= SEL_W'(N - 1);
        end else if (r_state == IDLE && w_lock_go) begin
            r_last_grant <= w_lock_tgt;
        end
    end
`else
    logic w_vld_sel;
    logic w_sel_ok;

    // A select beyond N never matches a mux leg, so w_vld_sel is 0 there.
    mux_n_1 #(.N(N), .W(1)) u_sel_mux (.i_dat(in_valid), .i_sel(sel), .o_dat(w_vld_sel));

    always_comb begin
        w_sel_ok   = (int'(sel) < N);
        w_lock_go  = w_sel_ok && w_vld_sel;
        w_lock_tgt = sel;
        w_sel_err  = !w_sel_ok && (|in_valid);
    end
`endif

    assign w_rdy_grant = !r_out_valid || out_ready;
    assign w_accept    = (r_state == LOCKED) && w_vld_grant && w_rdy_grant;

    always_comb begin
        in_ready = '0;
        if (r_state == LOCKED && w_rdy_grant) in_ready[r_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= (r_state == IDLE) && w_sel_err;

            if (r_state == IDLE) begin
                if (w_lock_go) begin
                    r_state <= LOCKED;
                    r_grant <= w_lock_tgt;
                end
            end else if (w_accept && w_last_grant) begin
                r_state <= IDLE;
            end

            // Accept and drain in the same cycle refills the register for full throughput.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data_grant;
                r_out_last  <= w_last_grant;
                r_out_chan  <= r_grant;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;
    assign busy      = (r_state == LOCKED);
    assign sel_err   = r_sel_err;

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-input, W-bit packet stream multiplexer with valid/ready handshakes on every channel.
- Generalises the fixed 4:1 combinational mux:
  - selects one of N channels;
  - locks that channel for a whole packet, up to and including the beat with last;
  - forwards the packet through a single output register stage.
- Sits between per-channel producers and a single downstream consumer, for example a shared bus or a serialiser.

Parameters:
- N, default 4: number of input channels (2..16).
- W, default 4: data width per channel in bits.
- SEL_W, derived localparam = $clog2(N): width of the select and channel-index fields. Not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sel  in  SEL_W  channel to lock when IDLE; ignored in LOCKED
- in_valid  in  N  per-channel beat valid
- in_ready  out  N  per-channel beat ready
- in_data  in  N*W  channel k occupies bits [k*W +: W]
- in_last  in  N  per-channel end-of-packet flag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  W  output beat data
- out_last  out  1  output end-of-packet flag
- out_chan  out  SEL_W  source channel of the current output beat
- busy  out  1  high while state is LOCKED
- sel_err  out  1  one-cycle pulse when sel >= N in IDLE and some in_valid is high

Behaviour:
- Reset (rst sampled high at a clk edge) values:
  - state = IDLE; grant = 0;
  - out_valid, out_last, busy, sel_err = 0;
  - out_data, out_chan = 0;
  - in_ready = 0.
- IDLE state:
  - in_ready = 0 on all channels.
  - If sel < N and in_valid[sel] = 1: next cycle grant = sel, state = LOCKED.
  - No beat is transferred in the locking cycle.
  - If sel >= N: stay IDLE. Pulse sel_err if any in_valid is high.
- LOCKED state:
  - in_ready[grant] = !out_valid || out_ready. All other in_ready bits = 0.
  - A beat is accepted when in_valid[grant] && in_ready[grant].
  - On acceptance, the output register loads in_data[grant], in_last[grant] and out_chan = grant, and out_valid is set.
  - Acceptance with in_last = 1 returns the state to IDLE on the next cycle.
- Output register:
  - out_valid clears when out_ready = 1 and no new beat is accepted that cycle.
  - Simultaneous drain and accept refills the register, giving full throughput of 1 beat/cycle.
  - out_* is held stable while out_valid && !out_ready.
- Latency: the input beat appears on out_* 1 cycle after acceptance.
- A new lock may occur while the last beat of the previous packet is still held in the output register.
- Changing sel during LOCKED has no effect.
- Reset mid-packet: the lock is dropped, and any beat in the output register is discarded (out_valid = 0 on the next cycle).
- Single-beat packet (in_last on the first beat): LOCKED lasts exactly 1 cycle if downstream is ready.

Optional Feature:
- Macro: STREAM_MUX_RR_EN.
- When defined:
  - The sel port is ignored and sel_err is tied to 0.
  - In IDLE the lock goes to the first channel with in_valid set, searching upward from (last_grant + 1) mod N with wrap-around.
  - last_grant resets to N-1, so channel 0 wins first.
  - last_grant is updated on each lock.
- When undefined: external sel selection as described in Behaviour.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum logic [0:0] {IDLE, LOCKED} state_t;
  - a function for the round-robin next-grant search.
- One sub-module is natural: mux_n_1. It is a parametrised combinational N:1, W-bit data mux (parameters N, W) used for both the data and last paths.

Test Plan:
1. Reset check: rst high for 2 cycles -> out_valid = 0, busy = 0, in_ready = 4'b0000, out_data = 0.
2. Basic 3-beat packet: sel = 2, ch2 sends 3-beat packet A1, A2, A3 (last on A3), out_ready = 1.
   - busy = 1 one cycle after valid.
   - out_data = A1, A2, A3 on consecutive cycles, out_chan = 2, out_last on A3.
   - Then busy = 0.
3. Backpressure and lock hold:
   - out_ready = 0 for 3 cycles mid-packet -> in_ready[2] = 0, out_data held stable, no beats lost or duplicated.
   - sel changed to 1 mid-packet -> still ch2 only.
4. Out-of-range select: N = 3, sel = 3, in_valid = 3'b111 -> sel_err pulses each cycle, state stays IDLE, no output.
5. Reset mid-packet: rst asserted after beat 1 of a 4-beat packet -> out_valid = 0 and busy = 0 on the next cycle. A new lock succeeds after reset.
6. STREAM_MUX_RR_EN build: all channels continuously valid with 1-beat packets -> grant order 0, 1, 2, 3, 0; ch1 idle -> order 0, 2, 3, 0.
